// File: rtl/cram_arb_pkg.sv
// cram_arb_pkg: shared FSM/grant types and constants for the cartridge RAM arbiter
package cram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;
  typedef enum logic {GRANT_LD, GRANT_SND} grant_e;
  localparam logic [7:0] RD_TIMEOUT_FILL = 8'hFF;
endpackage

// File: rtl/cram_arbiter.sv
// cram_arbiter: shares the cram controller between the ROM byte loader and the sound sample reader
module cram_arbiter
  import cram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int LOAD_BURST = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  ld_ack,
  input  logic                  snd_req,
  input  logic [ADDR_WIDTH-1:0] snd_addr,
  output logic [7:0]            snd_data,
  output logic                  snd_ack,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [15:0]           mem_wr_data,
  output logic [1:0]            mem_be,
  input  logic                  mem_busy,
  input  logic                  mem_rd_valid,
  input  logic [15:0]           mem_rd_data,
  output logic                  busy,
  output logic                  err
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(LOAD_BURST + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [BCW-1:0] BC_MAX = BCW'(LOAD_BURST);
  state_e state_q, state_d;
  grant_e grant_q, grant_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [ADDR_WIDTH-2:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wr_data_q, mem_wr_data_d;
  logic [1:0] mem_be_q, mem_be_d;
  logic [7:0] snd_data_q, snd_data_d;
  logic mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic ld_ack_q, ld_ack_d, snd_ack_q, snd_ack_d;
  logic busy_q, busy_d, err_q, err_d;
  logic grant_now, snd_wins, wd_exp, timeout;
  assign grant_now = (state_q == IDLE) && (ld_req || snd_req);
  // Loader keeps priority until it has taken LOAD_BURST slots in front of a waiting sound read
  assign snd_wins  = snd_req && (!ld_req || burst_q == BC_MAX);
  assign wd_exp    = wd_q == WD_MAX;
  assign timeout   = wd_exp && ((state_q == ISSUE && mem_busy) || (state_q == WAIT_RD && !mem_rd_valid));
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_now ? ISSUE : IDLE;
      ISSUE:   state_d = !mem_busy ? (grant_q == GRANT_SND ? WAIT_RD : DONE) : (wd_exp ? DONE : ISSUE);
      WAIT_RD: state_d = (mem_rd_valid || wd_exp) ? DONE : WAIT_RD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    grant_d       = grant_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_be_d      = mem_be_q;
    burst_d       = burst_q;
    if (grant_now) begin
      grant_d       = snd_wins ? GRANT_SND : GRANT_LD;
      mem_addr_d    = snd_wins ? snd_addr[ADDR_WIDTH-1:1] : ld_addr[ADDR_WIDTH-1:1];
      mem_be_d      = (snd_wins ? snd_addr[0] : ld_addr[0]) ? 2'b10 : 2'b01;
      mem_wr_data_d = {2{ld_data}};
      burst_d       = (!snd_wins && snd_req) ? burst_q + BCW'(1) : '0;
    end
    wd_d       = (state_d == state_q && (state_q == ISSUE || state_q == WAIT_RD)) ? wd_q + WDW'(1) : '0;
    mem_wr_d   = state_d == ISSUE && grant_d == GRANT_LD;
    mem_rd_d   = state_d == ISSUE && grant_d == GRANT_SND;
    ld_ack_d   = state_d == DONE && grant_q == GRANT_LD;
    snd_ack_d  = state_d == DONE && grant_q == GRANT_SND;
    busy_d     = state_d != IDLE;
    err_d      = err_q || timeout;
    snd_data_d = (state_q == WAIT_RD && mem_rd_valid) ? (mem_be_q[1] ? mem_rd_data[15:8] : mem_rd_data[7:0])
               : (timeout && grant_q == GRANT_SND) ? RD_TIMEOUT_FILL : snd_data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q       <= GRANT_LD;
      burst_q       <= '0;
      wd_q          <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_be_q      <= '0;
      snd_data_q    <= '0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      ld_ack_q      <= 1'b0;
      snd_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      burst_q       <= burst_d;
      wd_q          <= wd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_be_q      <= mem_be_d;
      snd_data_q    <= snd_data_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
      ld_ack_q      <= ld_ack_d;
      snd_ack_q     <= snd_ack_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_be      = mem_be_q;
  assign snd_data    = snd_data_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign ld_ack      = ld_ack_q;
  assign snd_ack     = snd_ack_q;
  assign busy        = busy_q;
  assign err         = err_q;
endmodule

// File: tb/tb_cram_arbiter.sv
// tb_cram_arbiter: directed vector table plus hand-written sequences for burst fairness, stalls, watchdog and reset
module tb_cram_arbiter;
  localparam int AW = 25;
  logic clk = 1'b0, reset_n = 1'b0;
  logic ld_req = 1'b0, snd_req = 1'b0, mem_busy = 1'b0, mem_rd_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0, snd_addr = '0;
  logic [7:0] ld_data = '0;
  logic [15:0] mem_rd_data = '0;
  logic ld_ack, snd_ack, mem_wr, mem_rd, busy, err;
  logic [7:0] snd_data;
  logic [AW-2:0] mem_addr;
  logic [15:0] mem_wr_data;
  logic [1:0] mem_be;
  int checks = 0, failures = 0;
  cram_arbiter #(.ADDR_WIDTH(AW), .LOAD_BURST(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .snd_req(snd_req), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ack(snd_ack),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_wr_data(mem_wr_data), .mem_be(mem_be),
    .mem_busy(mem_busy), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [7:0]    wbyte;
    logic [15:0]   rword;
    logic [AW-2:0] exp_addr;
    logic [1:0]    exp_be;
    logic [15:0]   exp_wdata;
    logic [7:0]    exp_rdata;
  } vec_t;
  vec_t vecs[7];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v);
    if (v.rd) begin
      snd_req = 1'b1;
      snd_addr = v.addr;
    end else begin
      ld_req = 1'b1;
      ld_addr = v.addr;
      ld_data = v.wbyte;
    end
    tick();
    chk("strobe_wr", mem_wr, !v.rd);
    chk("strobe_rd", mem_rd, v.rd);
    chk("mem_addr", mem_addr, v.exp_addr);
    chk("mem_be", mem_be, v.exp_be);
    chk("busy_c1", busy, 1);
    if (!v.rd) chk("mem_wr_data", mem_wr_data, v.exp_wdata);
    tick();
    if (v.rd) begin
      chk("rd_strobe_drop", mem_rd, 0);
      chk("snd_ack_c2", snd_ack, 0);
      mem_rd_valid = 1'b1;
      mem_rd_data = v.rword;
      tick();
      mem_rd_valid = 1'b0;
      chk("snd_ack_c3", snd_ack, 1);
      chk("snd_data", snd_data, v.exp_rdata);
      chk("no_ld_ack_rd", ld_ack, 0);
      snd_req = 1'b0;
    end else begin
      chk("ld_ack_c2", ld_ack, 1);
      chk("no_snd_ack_wr", snd_ack, 0);
      ld_req = 1'b0;
    end
    tick();
    chk("idle_busy", busy, 0);
    chk("ack_one_cycle", {ld_ack, snd_ack}, 0);
  endtask
  initial begin
    int seq[$];
    int exp_seq[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int nsnd, wr_cycles, ack_cyc;
    vecs[0] = '{1'b0, 25'h0000003, 8'hA5, 16'h0,    24'h000001, 2'b10, 16'hA5A5, 8'h00};
    vecs[1] = '{1'b0, 25'h0000000, 8'h3C, 16'h0,    24'h000000, 2'b01, 16'h3C3C, 8'h00};
    vecs[2] = '{1'b0, 25'h1FFFFFF, 8'hFF, 16'h0,    24'hFFFFFF, 2'b10, 16'hFFFF, 8'h00};
    vecs[3] = '{1'b1, 25'h0000010, 8'h00, 16'h1234, 24'h000008, 2'b01, 16'h0,    8'h34};
    vecs[4] = '{1'b1, 25'h0000011, 8'h00, 16'h1234, 24'h000008, 2'b10, 16'h0,    8'h12};
    vecs[5] = '{1'b1, 25'h1ABCDE5, 8'h00, 16'hBEEF, 24'hD5E6F2, 2'b10, 16'h0,    8'hBE};
    vecs[6] = '{1'b0, 25'h0ABCDE4, 8'h5A, 16'h0,    24'h55E6F2, 2'b01, 16'h5A5A, 8'h00};
    tick();
    tick();
    chk("rst_outputs", {ld_ack, snd_ack, mem_wr, mem_rd, busy, err}, 0);
    chk("rst_data", {snd_data, mem_wr_data, mem_be}, 0);
    chk("rst_addr", mem_addr, 0);
    reset_n = 1'b1;
    tick();
    foreach (vecs[i]) run_vec(vecs[i]);
    // Loader held continuously against a persistent sound requester
    mem_rd_valid = 1'b1;
    mem_rd_data = 16'hC3D2;
    snd_addr = 25'h0000020;
    ld_req = 1'b1;
    snd_req = 1'b1;
    nsnd = 0;
    for (int c = 0; c < 200 && seq.size() < 11; c++) begin
      tick();
      if (ld_ack && snd_ack) chk("dual_ack", {ld_ack, snd_ack}, 2'b10);
      if (ld_ack) begin
        seq.push_back(0);
        ld_addr = ld_addr + 1;
      end
      if (snd_ack) begin
        seq.push_back(1);
        chk("burst_snd_data", snd_data, 8'hD2);
        nsnd++;
        if (nsnd == 2) snd_req = 1'b0;
      end
    end
    chk("burst_len", seq.size(), 11);
    for (int i = 0; i < 11; i++) chk($sformatf("burst_seq%0d", i), i < seq.size() ? seq[i] : -1, exp_seq[i]);
    ld_req = 1'b0;
    snd_req = 1'b0;
    mem_rd_valid = 1'b0;
    tick();
    tick();
    chk("burst_idle", busy, 0);
    // Write stalled by five busy cycles
    ld_req = 1'b1;
    ld_addr = 25'h0000100;
    ld_data = 8'h77;
    mem_busy = 1'b1;
    wr_cycles = 0;
    ack_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 6) mem_busy = 1'b0;
      if (mem_wr) wr_cycles++;
      if (ld_ack) begin
        ack_cyc = c;
        ld_req = 1'b0;
      end
    end
    chk("stall_wr_cycles", wr_cycles, 6);
    chk("stall_ack_cycle", ack_cyc, 7);
    chk("stall_no_err", err, 0);
    // Read whose data never arrives
    snd_req = 1'b1;
    snd_addr = 25'h0000031;
    ack_cyc = -1;
    for (int c = 1; c <= 300 && ack_cyc < 0; c++) begin
      tick();
      if (c == 257) chk("to_err_before", err, 0);
      if (snd_ack) begin
        ack_cyc = c;
        snd_req = 1'b0;
        chk("to_snd_data", snd_data, 8'hFF);
        chk("to_err_set", err, 1);
      end
    end
    chk("to_ack_cycle", ack_cyc, 258);
    for (int c = 0; c < 5; c++) tick();
    chk("to_err_sticky", err, 1);
    // Reset pulse while waiting on read data
    snd_req = 1'b1;
    snd_addr = 25'h0000041;
    tick();
    tick();
    chk("rst_mid_busy", busy, 1);
    reset_n = 1'b0;
    snd_req = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_mid_ctrl", {ld_ack, snd_ack, mem_wr, mem_rd, busy, err}, 0);
    chk("rst_mid_data", {snd_data, mem_wr_data, mem_be}, 0);
    chk("rst_mid_addr", mem_addr, 0);
    mem_rd_valid = 1'b1;
    mem_rd_data = 16'h9999;
    ack_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (snd_ack || busy) ack_cyc++;
    end
    mem_rd_valid = 1'b0;
    chk("late_valid_ignored", ack_cyc, 0);
    chk("late_snd_data", snd_data, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
